// File: rtl/instr_encoder_queue.sv
// instr_encoder_queue: packs MIPS32 instruction descriptors into machine words
// and buffers {word, address} pairs in a small FIFO for the loader/fetch path.
module instr_encoder_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm16,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [15:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [31:0]   word;
    logic          legal, accept, push, pop;

    assign in_ready    = occ_q != FULL_OCC;
    assign out_valid   = occ_q != '0;
    assign out_instr   = out_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
    assign out_addr    = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign err_illegal = err_q;
    assign count       = count_q;

    assign legal  = in_op <= 4'd10;
    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        word = 32'h0;
        case (in_op)
            4'd0:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h21};
            4'd1:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h23};
            4'd2:    word = {6'h00, in_rs, 15'b0, 6'h08};
            4'd3:    word = 32'h0000_000C;
            4'd4:    word = {6'h0D, in_rs, in_rt, in_imm16};
            4'd5:    word = {6'h0F, 5'b0, in_rt, in_imm16};
            4'd6:    word = {6'h23, in_rs, in_rt, in_imm16};
            4'd7:    word = {6'h2B, in_rs, in_rt, in_imm16};
            4'd8:    word = {6'h04, in_rs, in_rt, in_imm16};
            4'd9:    word = {6'h02, in_target};
            4'd10:   word = {6'h03, in_target};
            default: word = 32'h0;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {word, addr_q};
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d    = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
        addr_d   = push ? addr_q + 32'd4 : addr_q;
        count_d  = count_q + 16'(pop);
        err_d    = accept && !legal;
    end

    // Storage needs no reset: reads are masked while occupancy is zero.
    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= BASE_ADDR;
            count_q  <= 16'h0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: doc/instr_encoder_queue.md
# instr_encoder_queue

Sequential MIPS32 instruction encoder: the inverse of the core's instruction decoder. Accepts instruction descriptions (operation code plus register/immediate fields) over a valid/ready handshake and packs each one into its 32-bit machine word. Each word gets a sequential text-segment address and is buffered in a small FIFO. Sits in the program-loader / self-test path, feeding instruction memory or the fetch stage with words the decoder understands.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_3000, address assigned to the first word after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input descriptor valid
- in_ready  out  1  encoder can accept; equals !full
- in_op  in  4  0 addu, 1 subu, 2 jr, 3 syscall, 4 ori, 5 lui, 6 lw, 7 sw, 8 beq, 9 j, 10 jal; 11–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm16  in  16  immediate
- in_target  in  26  jump target field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_instr  out  32  encoded word at head
- out_addr  out  32  address of head word
- err_illegal  out  1  one-cycle pulse: illegal op was consumed
- count  out  16  words popped since reset, wraps 16'hFFFF→0

## Operation
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Encoding (fields not used by the op are forced to 0, inputs ignored):
  - addu/subu: {6'h00, rs, rt, rd, 5'b0, 6'h21/6'h23}
  - jr: {6'h00, rs, 15'b0, 6'h08}; syscall: 32'h0000_000C
  - ori: {6'h0D, rs, rt, imm16}; lui: {6'h0F, 5'b0, rt, imm16}
  - lw/sw/beq: {6'h23/6'h2B/6'h04, rs, rt, imm16}
  - j/jal: {6'h02/6'h03, target}
- Legal accept: push {word, addr_reg}; addr_reg += 4, modulo 2^32 (wraps 32'hFFFF_FFFC→0).
- Illegal accept: descriptor dropped, no push, addr_reg unchanged; err_illegal=1 next cycle only.
- FIFO: occupancy counter 0..DEPTH; states EMPTY (0), PARTIAL, FULL (DEPTH). Read/write pointers wrap modulo DEPTH.
  - Push only: occ+1. Pop only: occ−1. Push and pop together (not FULL): occ unchanged.
  - FULL: in_ready=0 regardless of out_ready; no same-cycle push-through.
  - EMPTY: out_valid=0, out_instr=0, out_addr=0.
- Order preserved; a word is never duplicated or lost.
- count increments on each pop.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=0, err_illegal=0, count=0, occ=0, addr_reg=BASE_ADDR.
- Latency: descriptor accepted at edge N → out_valid=1 with its word from after edge N (visible cycle N+1) if FIFO was empty.
- in_ready and out_valid derive from registered occupancy only; no combinational path from inputs to in_ready/out_valid.
- out_instr/out_addr stable while out_valid && !out_ready.
- rst asserted mid-operation: all queued words discarded and outputs at reset values the cycle after. A pending err_illegal pulse is cancelled. Descriptors presented during the reset cycle are not accepted.

## Test plan
- Reset, push addu rs=1 rt=2 rd=3 → next cycle out_valid=1, out_instr=32'h0022_1821, out_addr=32'h0000_3000; pop → count=1.
- Push ori rs=0 rt=8 imm=16'h1234; lui rs=7 rt=1 imm=16'hFFFF; beq rs=1 rt=2 imm=16'hFFFF; jal target=26'h0000C00; syscall with all fields 5'h1F → 32'h3408_1234, 32'h3C01_FFFF, 32'h1022_FFFF, 32'h0C00_0C00, 32'h0000_000C; addrs 0x3000–0x3010.
- out_ready=0, hold in_valid with 5 descriptors → in_ready=0 after 4th accept, 5th held. Release out_ready → words in order, addrs 0x3000,0x3004,0x3008,0x300C,0x3010.
- Legal, in_op=4'hF, legal → err_illegal high exactly one cycle; two words at 0x3000 and 0x3004.
- 3 words queued, assert rst one cycle → out_valid=0, count=0; next push gets out_addr=0x3000.
- Occupancy 1, simultaneous push and pop → occupancy stays 1, count+1, in_ready stays 1, popped word is the older one.
